// File: rtl/bram_reader_pkg.sv
// Shared types and default geometry for the block-RAM stream reader.
package bram_reader_pkg;

  localparam int DEFAULT_WORD_LENGTH   = 16;
  localparam int DEFAULT_ADDRESS_WIDTH = 17;
  localparam int DEFAULT_LAST_ADDRESS  = 125000;

  typedef logic [DEFAULT_WORD_LENGTH-1:0]   word_t;
  typedef logic [DEFAULT_ADDRESS_WIDTH-1:0] address_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FINISH
  } reader_state_t;

endpackage

// File: rtl/bram_stream_reader_if.sv
// Valid/ready word stream leaving the reader; master drives data/valid.
interface bram_stream_reader_if
  import bram_reader_pkg::*;
#(
  parameter int WORD_LENGTH = DEFAULT_WORD_LENGTH
);
  logic [WORD_LENGTH-1:0] outData;
  logic                   outValid;
  logic                   outReady;

  modport master (output outData, output outValid, input outReady);
  modport slave  (input outData, input outValid, output outReady);
endinterface

// File: rtl/bram_reader_skid_fifo.sv
// Two-entry first-word-fall-through register buffer; head is always visible.
module bram_reader_skid_fifo #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] headData,
  output logic             headValid
);
  logic [WIDTH-1:0] tailData;

  assign headValid = (count != 2'd0);

  // Head/tail shuffle; a push into a full buffer without a pop cannot occur
  // because the issuer never reserves more than two slots.
  always_ff @(posedge clock) begin
    if (reset) begin
      count    <= 2'd0;
      headData <= '0;
      tailData <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) headData <= pushData;
          else               tailData <= pushData;
          if (count != 2'd2) count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) headData <= tailData;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) headData <= pushData;
          else if (count == 2'd2) begin
            headData <= tailData;
            tailData <= pushData;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/bram_stream_reader.sv
// Read-side master for the single-port block RAM: issues sequential reads,
// absorbs the one-cycle RAM latency in a 2-entry buffer and streams words out.
// Optional macro BRAM_READER_WRAP_EN: addresses wrap past LAST_ADDRESS to 0,
// length is clamped to the RAM size and commands are never rejected.
module bram_stream_reader
  import bram_reader_pkg::*;
#(
  parameter int WORD_LENGTH   = DEFAULT_WORD_LENGTH,
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int LAST_ADDRESS  = DEFAULT_LAST_ADDRESS
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] baseAddress,
  input  logic [ADDRESS_WIDTH-1:0] length,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic                     memEnable,
  output logic                     memWriteEnable,
  output logic [ADDRESS_WIDTH-1:0] memAddress,
  input  logic [WORD_LENGTH-1:0]   memDataIn,
  bram_stream_reader_if.master     stream
);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(LAST_ADDRESS);
  localparam logic [ADDRESS_WIDTH-1:0] ONE       = ADDRESS_WIDTH'(1);

  reader_state_t              state;
  logic [ADDRESS_WIDTH-1:0]   remaining;
  logic                       inflight;
  logic [1:0]                 count;
  logic                       pop;
  logic                       issue;
  logic [2:0]                 occupancy;
  logic [ADDRESS_WIDTH-1:0]   nextAddress;
  logic [ADDRESS_WIDTH-1:0]   startLength;
  logic                       rangeBad;

  assign pop       = stream.outValid && stream.outReady;
  // Slots already claimed once this cycle's pop is accounted for.
  assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  // Issue is combinational so a never-stalling consumer sees no bubbles.
  assign issue          = (state == ISSUE) && (occupancy < 3'd2);
  assign memEnable      = issue;
  assign memWriteEnable = 1'b0;

`ifdef BRAM_READER_WRAP_EN
  localparam logic [ADDRESS_WIDTH-1:0] MAX_LENGTH = ADDRESS_WIDTH'(LAST_ADDRESS + 1);
  assign nextAddress = (memAddress == LAST_ADDR) ? '0 : memAddress + ONE;
  assign startLength = (length > MAX_LENGTH) ? MAX_LENGTH : length;
  assign rangeBad    = 1'b0;
`else
  localparam logic [ADDRESS_WIDTH:0] LAST_EXT = (ADDRESS_WIDTH+1)'(LAST_ADDRESS);
  logic [ADDRESS_WIDTH:0] endAddress;
  // One extra bit so base+length cannot wrap before the compare.
  assign endAddress  = {1'b0, baseAddress} + {1'b0, length} - (ADDRESS_WIDTH+1)'(1);
  assign nextAddress = memAddress + ONE;
  assign startLength = length;
  assign rangeBad    = (endAddress > LAST_EXT);
`endif

  // Command FSM with address/remaining counters and registered status pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      memAddress <= '0;
      remaining  <= '0;
      inflight   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      inflight <= issue;
      done     <= 1'b0;
      error    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (startLength == '0) begin
              state <= FINISH;
              busy  <= 1'b1;
              done  <= 1'b1;
            end else if (rangeBad) begin
              error <= 1'b1;
            end else begin
              state      <= ISSUE;
              busy       <= 1'b1;
              memAddress <= baseAddress;
              remaining  <= startLength;
            end
          end
        end
        ISSUE: begin
          if (issue) begin
            memAddress <= nextAddress;
            remaining  <= remaining - ONE;
            if (remaining == ONE) state <= DRAIN;
          end
        end
        DRAIN: begin
          // Nothing in flight and the buffer empties on this edge.
          if (occupancy == 3'd0) begin
            state <= FINISH;
            done  <= 1'b1;
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  bram_reader_skid_fifo #(.WIDTH(WORD_LENGTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (inflight),
    .pushData  (memDataIn),
    .pop       (pop),
    .count     (count),
    .headData  (stream.outData),
    .headValid (stream.outValid)
  );
endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench for bram_stream_reader with a scoreboard on the stream.
module tb_bram_stream_reader;
  import bram_reader_pkg::*;

  logic     clock = 1'b0;
  logic     reset = 1'b1;
  logic     start = 1'b0;
  address_t baseAddress = '0;
  address_t length = '0;
  logic     busy, done, error, memEnable, memWriteEnable;
  address_t memAddress;
  word_t    memDataIn = '0;

  bram_stream_reader_if intf ();

  bram_stream_reader dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .baseAddress    (baseAddress),
    .length         (length),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .memEnable      (memEnable),
    .memWriteEnable (memWriteEnable),
    .memAddress     (memAddress),
    .memDataIn      (memDataIn),
    .stream         (intf.master)
  );

  always #5 clock = ~clock;

  // RAM model: mem[a] = a, one-cycle registered read.
  always @(posedge clock) if (memEnable) memDataIn <= word_t'(memAddress);

  int    compared   = 0;
  int    mismatched = 0;
  word_t expQ[$];

  function automatic address_t next_addr(address_t a);
`ifdef BRAM_READER_WRAP_EN
    return (a == address_t'(DEFAULT_LAST_ADDRESS)) ? '0 : a + address_t'(1);
`else
    return a + address_t'(1);
`endif
  endfunction

  task automatic push_expected(address_t base, int len);
    address_t a = base;
    for (int i = 0; i < len; i++) begin
      expQ.push_back(word_t'(a));
      a = next_addr(a);
    end
  endtask

  // Stream monitor: scoreboard pop, stall stability, buffer occupancy model.
  int    mCount = 0;
  int    mInflight = 0;
  bit    prevStall = 0;
  word_t stallData = '0;
  bit    mPop;
  word_t expW;
  always @(negedge clock) begin
    if (reset) begin
      mCount = 0; mInflight = 0; prevStall = 0;
    end else begin
      mPop = intf.outValid && intf.outReady;
      compared++;
      if (intf.outValid !== (mCount != 0)) begin
        mismatched++;
        $display("FAIL out_valid: got %0b want %0b", intf.outValid, mCount != 0);
      end
      if (prevStall) begin
        compared++;
        if (intf.outValid !== 1'b1 || intf.outData !== stallData) begin
          mismatched++;
          $display("FAIL stall_hold: got v=%0b d=%0d want v=1 d=%0d", intf.outValid, intf.outData, stallData);
        end
      end
      if (memEnable) begin
        compared++;
        if (mCount + mInflight - int'(mPop) >= 2) begin
          mismatched++;
          $display("FAIL issue_rule: occupancy %0d want <2", mCount + mInflight - int'(mPop));
        end
      end
      if (mPop) begin
        compared++;
        if (expQ.size() == 0) begin
          mismatched++;
          $display("FAIL extra_word: got %0d want none", intf.outData);
        end else begin
          expW = expQ.pop_front();
          if (intf.outData !== expW) begin
            mismatched++;
            $display("FAIL stream_data: got %0d want %0d", intf.outData, expW);
          end
        end
      end
      mCount    = mCount + mInflight - int'(mPop);
      mInflight = int'(memEnable);
      prevStall = intf.outValid && !intf.outReady;
      stallData = intf.outData;
    end
  end

  // Drive a one-cycle start; returns at #1 after the accepting edge E0.
  task automatic issue_cmd(address_t base, address_t len);
    @(posedge clock); #1;
    start = 1'b1; baseAddress = base; length = len;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic run_until_done(int budget, string name);
    bit seen = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clock);
      if (done) seen = 1;
    end
    compared++;
    if (!seen) begin
      mismatched++;
      $display("FAIL %s_timeout: got no done want done within %0d cycles", name, budget);
    end
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("FAIL %s_words: got %0d undelivered want 0", name, expQ.size());
    end
  endtask

  task automatic check_all_zero(string name);
    logic [7:0] got;
    got = {busy, done, error, memEnable, memWriteEnable, |memAddress, |intf.outData, intf.outValid};
    compared++;
    if (got !== 8'h00) begin
      mismatched++;
      $display("FAIL %s: got flags %b want 00000000", name, got);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    intf.outReady = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_all_zero("reset_outputs");
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int firstValid = -1, doneAt = -1, doneCount = 0, nIssue = 0;
    intf.outReady = 1'b1;
    push_expected(100, 4);
    issue_cmd(100, 4);
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (memEnable) begin
        compared++;
        if (k > 3 || memAddress !== address_t'(100 + k)) begin
          mismatched++;
          $display("FAIL basic_addr: cycle %0d got %0d want %0d", k, memAddress, 100 + k);
        end
        nIssue++;
      end
      if (intf.outValid && firstValid < 0) firstValid = k;
      if (done) begin doneCount++; doneAt = k; end
      if (k == 0 || k == 6 || k == 7) begin
        compared++;
        if (busy !== (k != 7)) begin
          mismatched++;
          $display("FAIL basic_busy: cycle %0d got %0b want %0b", k, busy, k != 7);
        end
      end
    end
    compared++;
    if (nIssue != 4) begin mismatched++; $display("FAIL basic_issues: got %0d want 4", nIssue); end
    compared++;
    if (firstValid != 2) begin mismatched++; $display("FAIL basic_latency: got %0d want 2", firstValid); end
    compared++;
    if (doneCount != 1 || doneAt != 6) begin
      mismatched++;
      $display("FAIL basic_done: got count %0d at %0d want 1 at 6", doneCount, doneAt);
    end
    compared++;
    if (expQ.size() != 0) begin mismatched++; $display("FAIL basic_words: got %0d left want 0", expQ.size()); end
  endtask

  task automatic test_backpressure();
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bit seen = 0;
    push_expected(100, 4);
    issue_cmd(100, 4);
    for (int k = 0; k < 60 && !seen; k++) begin
      intf.outReady = pat[k % 4];
      // A second command while busy must be ignored.
      if (k == 1) begin start = 1'b1; baseAddress = 50; length = 2; end
      if (k == 2) start = 1'b0;
      @(negedge clock);
      if (done) seen = 1;
      @(posedge clock); #1;
    end
    compared++;
    if (!seen) begin mismatched++; $display("FAIL bp_timeout: got no done want done"); end
    compared++;
    if (expQ.size() != 0) begin mismatched++; $display("FAIL bp_words: got %0d left want 0", expQ.size()); end
    intf.outReady = 1'b1;
    repeat (3) @(posedge clock);
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL bp_ignored_start: got busy %0b want 0", busy); end
  endtask

  task automatic test_zero_length();
    bit anyEnable = 0;
    issue_cmd(7, 0);
    @(negedge clock);
    compared++;
    if ({done, busy, error} !== 3'b110) begin
      mismatched++;
      $display("FAIL zero_done: got done/busy/error %b want 110", {done, busy, error});
    end
    if (memEnable) anyEnable = 1;
    for (int k = 1; k < 4; k++) begin
      @(negedge clock);
      if (memEnable) anyEnable = 1;
      if (k == 1) begin
        compared++;
        if ({done, busy} !== 2'b00) begin
          mismatched++;
          $display("FAIL zero_idle: got done/busy %b want 00", {done, busy});
        end
      end
    end
    compared++;
    if (anyEnable) begin mismatched++; $display("FAIL zero_mem: got memEnable 1 want 0"); end
  endtask

  task automatic test_range();
`ifdef BRAM_READER_WRAP_EN
    address_t want[3] = '{address_t'(124999), address_t'(125000), address_t'(0)};
    int n = 0;
    bit seen = 0;
    push_expected(124999, 3);
    issue_cmd(124999, 3);
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clock);
      if (memEnable) begin
        compared++;
        if (n > 2 || memAddress !== want[n]) begin
          mismatched++;
          $display("FAIL wrap_addr: issue %0d got %0d", n, memAddress);
        end
        n++;
      end
      if (error) begin compared++; mismatched++; $display("FAIL wrap_error: got 1 want 0"); end
      if (done) seen = 1;
    end
    compared++;
    if (!seen || n != 3 || expQ.size() != 0) begin
      mismatched++;
      $display("FAIL wrap_words: got done %0b issues %0d left %0d want 1 3 0", seen, n, expQ.size());
    end
`else
    bit anyEnable = 0;
    issue_cmd(124999, 3);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (memEnable) anyEnable = 1;
      if (k < 2) begin
        compared++;
        if ({error, busy, done} !== {k == 0, 2'b00}) begin
          mismatched++;
          $display("FAIL range_error: cycle %0d got err/busy/done %b want %b", k, {error, busy, done}, {k == 0, 2'b00});
        end
      end
    end
    compared++;
    if (anyEnable) begin mismatched++; $display("FAIL range_mem: got memEnable 1 want 0"); end
    // Last word exactly at LAST_ADDRESS is accepted.
    push_expected(124998, 3);
    issue_cmd(124998, 3);
    @(negedge clock);
    compared++;
    if ({busy, error} !== 2'b10) begin
      mismatched++;
      $display("FAIL range_edge_accept: got busy/error %b want 10", {busy, error});
    end
    run_until_done(20, "range_edge");
`endif
  endtask

  task automatic test_reset_mid();
    intf.outReady = 1'b0;
    issue_cmd(200, 8);
    @(posedge clock);
    @(posedge clock); #1;
    reset = 1'b1;
    expQ.delete();
    @(posedge clock);
    @(negedge clock);
    check_all_zero("reset_mid_outputs");
    @(posedge clock); #1;
    reset = 1'b0;
    intf.outReady = 1'b1;
    push_expected(5, 1);
    issue_cmd(5, 1);
    run_until_done(20, "reset_fresh");
  endtask

  initial begin
    intf.outReady = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_length();
    test_range();
    test_reset_mid();
    repeat (2) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
